// File: rtl/pcq_clks_pm_seq.sv
// Power-management thold sequencer: quiesce, ccflush disable, settle, raise tholds.
// Optional quiesce timeout under macro PCQ_PM_QUIESCE_TIMEOUT_EN.
`ifndef NCLK_WIDTH
`define NCLK_WIDTH 2
`endif

module pcq_clks_pm_seq #(
  parameter int THREADS        = 2,
  parameter int SETTLE_CYCLES  = 8,
  parameter int WAKE_CYCLES    = 4,
  parameter int CNT_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic [`NCLK_WIDTH-1:0] nclk,
  input  logic [THREADS-1:0]     pm_sleep_req,
  input  logic                   pm_quiesced,
  input  logic                   rg_ck_fast_xstop,
  input  logic                   lbist_en_dc,
  input  logic                   gsd_test_enable_dc,
  output logic                   ct_ck_pm_ccflush_disable,
  output logic                   ct_ck_pm_raise_tholds,
  output logic [THREADS-1:0]     pm_sleep_ack,
  output logic                   pm_timeout_err,
  output logic [2:0]             pm_state
);

  typedef enum logic [2:0] {
    S_RUN      = 3'b000,
    S_QUIESCE  = 3'b001,
    S_FLUSHDIS = 3'b010,
    S_SLEEP    = 3'b011,
    S_WAKE     = 3'b100
  } state_t;

  logic w_clk;
  logic w_rst;
  assign w_clk = nclk[0];
  assign w_rst = nclk[1];

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 w_sleep_all;
  logic                 w_ovr;
  logic                 w_to_fire;
  logic                 w_entry_ok;

  logic                 r_ccf;
  logic                 r_thold;
  logic [THREADS-1:0]   r_ack;

  assign w_sleep_all = &pm_sleep_req;
  assign w_ovr       = lbist_en_dc | gsd_test_enable_dc;

`ifdef PCQ_PM_QUIESCE_TIMEOUT_EN
  logic [TO_WIDTH-1:0] r_to_cnt;
  logic                r_to_blk;
  logic                r_err;

  assign w_to_fire = ~w_ovr & (r_state == S_QUIESCE) & w_sleep_all &
                     ~pm_quiesced &
                     (r_to_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1));
  // After a timeout, a fresh sleep_all edge is needed to retry.
  assign w_entry_ok = ~r_to_blk;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_to_cnt <= '0;
      r_to_blk <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_ovr || (r_state != S_QUIESCE))
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + 1'b1;
      if (!w_sleep_all)
        r_to_blk <= 1'b0;
      else if (w_to_fire)
        r_to_blk <= 1'b1;
      r_err <= w_to_fire;
    end
  end

  assign pm_timeout_err = r_err;
`else
  assign w_to_fire      = 1'b0;
  assign w_entry_ok     = 1'b1;
  assign pm_timeout_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_ovr) begin
      w_state_nxt = S_RUN;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_sleep_all && !rg_ck_fast_xstop && w_entry_ok)
            w_state_nxt = S_QUIESCE;
        end
        S_QUIESCE: begin
          if (!w_sleep_all) begin
            w_state_nxt = S_RUN;
          end else if (pm_quiesced) begin
            w_state_nxt = S_FLUSHDIS;
            w_cnt_nxt   = CNT_WIDTH'(SETTLE_CYCLES - 1);
          end else if (w_to_fire) begin
            w_state_nxt = S_RUN;
          end
        end
        S_FLUSHDIS: begin
          if (!w_sleep_all) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
          end else if (r_cnt == '0) begin
            w_state_nxt = S_SLEEP;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        S_SLEEP: begin
          if (!w_sleep_all) begin
            w_state_nxt = S_WAKE;
            w_cnt_nxt   = CNT_WIDTH'(WAKE_CYCLES - 1);
          end
        end
        S_WAKE: begin
          if (r_cnt == '0)
            w_state_nxt = S_RUN;
          else
            w_cnt_nxt = r_cnt - 1'b1;
        end
        default: begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they align with r_state.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
      r_ccf   <= 1'b0;
      r_thold <= 1'b0;
      r_ack   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ccf   <= (w_state_nxt == S_FLUSHDIS) |
                 (w_state_nxt == S_SLEEP) |
                 (w_state_nxt == S_WAKE);
      r_thold <= (w_state_nxt == S_SLEEP);
      r_ack   <= {THREADS{w_state_nxt == S_SLEEP}};
    end
  end

  assign ct_ck_pm_ccflush_disable = r_ccf;
  assign ct_ck_pm_raise_tholds    = r_thold;
  assign pm_sleep_ack             = r_ack;
  assign pm_state                 = r_state;

endmodule

// File: tb/tb_pcq_clks_pm_seq.sv
// Bench for pcq_clks_pm_seq: directed scenarios plus random traffic
// checked each cycle against a phase/age reference model.
`ifndef NCLK_WIDTH
`define NCLK_WIDTH 2
`endif

module tb_pcq_clks_pm_seq;

  localparam int SETTLE  = 8;
  localparam int WAKEC   = 4;
  localparam int TIMEOUT = 16;
`ifdef PCQ_PM_QUIESCE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int RUN = 0, QUI = 1, FLD = 2, SLP = 3, WAK = 4;

  logic                   clk;
  logic                   rst;
  logic [`NCLK_WIDTH-1:0] nclk;
  logic [1:0]             req;
  logic                   quiesced;
  logic                   xstop;
  logic                   lbist;
  logic                   gsd;
  logic                   ccf;
  logic                   thold;
  logic [1:0]             ack;
  logic                   err;
  logic [2:0]             st;

  assign nclk = {rst, clk};

  pcq_clks_pm_seq #(
    .THREADS(2), .SETTLE_CYCLES(SETTLE), .WAKE_CYCLES(WAKEC),
    .CNT_WIDTH(4), .TIMEOUT_CYCLES(TIMEOUT), .TO_WIDTH(8)
  ) dut (
    .nclk(nclk),
    .pm_sleep_req(req),
    .pm_quiesced(quiesced),
    .rg_ck_fast_xstop(xstop),
    .lbist_en_dc(lbist),
    .gsd_test_enable_dc(gsd),
    .ct_ck_pm_ccflush_disable(ccf),
    .ct_ck_pm_raise_tholds(thold),
    .pm_sleep_ack(ack),
    .pm_timeout_err(err),
    .pm_state(st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int m_state = RUN;
  int m_age   = 0;
  bit m_blk   = 1'b0;
  bit m_err   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = RUN;
    m_age   = 0;
    m_blk   = 1'b0;
    m_err   = 1'b0;
  endtask

  // Each state is described by how long it has lasted (m_age).
  task automatic model_step();
    int ns;
    bit sa;
    bit fire;
    sa   = (req == 2'b11);
    fire = 1'b0;
    ns   = m_state;
    if (lbist || gsd) begin
      ns = RUN;
    end else begin
      case (m_state)
        RUN: if (sa && !xstop && !m_blk) ns = QUI;
        QUI: begin
          if (!sa) ns = RUN;
          else if (quiesced) ns = FLD;
          else if (TO_EN && m_age == TIMEOUT) begin
            ns   = RUN;
            fire = 1'b1;
          end
        end
        FLD: begin
          if (!sa) ns = RUN;
          else if (m_age == SETTLE) ns = SLP;
        end
        SLP: if (!sa) ns = WAK;
        WAK: if (m_age == WAKEC) ns = RUN;
        default: ns = RUN;
      endcase
    end
    m_age = (ns == m_state) ? m_age + 1 : 1;
    if (!sa) m_blk = 1'b0;
    else if (fire) m_blk = 1'b1;
    m_err   = fire;
    m_state = ns;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".state"}, 32'(st), 32'(m_state));
    chk({tag, ".ccf"}, 32'(ccf),
        32'(m_state == FLD || m_state == SLP || m_state == WAK));
    chk({tag, ".thold"}, 32'(thold), 32'(m_state == SLP));
    chk({tag, ".ack"}, 32'(ack), (m_state == SLP) ? 32'd3 : 32'd0);
    chk({tag, ".err"}, 32'(err), 32'(m_err));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst) model_step();
    #1;
    chk_model(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic go_sleep();
    req      = 2'b11;
    quiesced = 1'b1;
    ticks(SETTLE + 2, "go_sleep");
    chk("go_sleep.reached", 32'(st), 32'd3);
  endtask

  initial begin
    rst      = 1'b1;
    req      = 2'b00;
    quiesced = 1'b0;
    xstop    = 1'b0;
    lbist    = 1'b0;
    gsd      = 1'b0;
    model_reset();
    #1;
    chk_model("reset");
    chk("reset.state", 32'(st), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick("idle");

    // Entry sequence
    req      = 2'b11;
    quiesced = 1'b1;
    tick("entry.c1");
    chk("entry.c1.state", 32'(st), 32'd1);
    chk("entry.c1.ccf", 32'(ccf), 32'd0);
    tick("entry.c2");
    chk("entry.c2.state", 32'(st), 32'd2);
    chk("entry.c2.ccf", 32'(ccf), 32'd1);
    ticks(7, "entry.settle");
    chk("entry.c9.thold", 32'(thold), 32'd0);
    tick("entry.c10");
    chk("entry.c10.thold", 32'(thold), 32'd1);
    chk("entry.c10.ack", 32'(ack), 32'd3);

    // Wake sequence; requests during WAKE are ignored
    req = 2'b01;
    tick("wake.m1");
    chk("wake.m1.state", 32'(st), 32'd4);
    chk("wake.m1.thold", 32'(thold), 32'd0);
    chk("wake.m1.ccf", 32'(ccf), 32'd1);
    req = 2'b11;
    ticks(3, "wake.hold");
    chk("wake.m4.ccf", 32'(ccf), 32'd1);
    req = 2'b00;
    tick("wake.m5");
    chk("wake.m5.state", 32'(st), 32'd0);
    chk("wake.m5.ccf", 32'(ccf), 32'd0);

    // Abort in FLUSHDIS
    req      = 2'b11;
    quiesced = 1'b1;
    ticks(5, "abort.pre");
    chk("abort.c5.state", 32'(st), 32'd2);
    req = 2'b01;
    tick("abort.c6");
    chk("abort.c6.state", 32'(st), 32'd0);
    chk("abort.c6.ccf", 32'(ccf), 32'd0);
    chk("abort.c6.thold", 32'(thold), 32'd0);

    // Override
    go_sleep();
    gsd = 1'b1;
    tick("ovr.c1");
    chk("ovr.c1.state", 32'(st), 32'd0);
    chk("ovr.c1.ccf", 32'(ccf), 32'd0);
    ticks(3, "ovr.hold");
    chk("ovr.hold.state", 32'(st), 32'd0);
    gsd = 1'b0;
    tick("ovr.release");
    chk("ovr.release.state", 32'(st), 32'd1);
    req = 2'b00;
    tick("ovr.idle");

    // Asynchronous reset mid-SLEEP
    go_sleep();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk_model("arst");
    chk("arst.ccf", 32'(ccf), 32'd0);
    chk("arst.thold", 32'(thold), 32'd0);
    req = 2'b00;
    tick("arst.hold");
    rst = 1'b0;
    tick("arst.release");

    // Quiesce timeout
    req      = 2'b11;
    quiesced = 1'b0;
    ticks(TIMEOUT, "to.wait");
    chk("to.c16.state", 32'(st), 32'd1);
    chk("to.c16.err", 32'(err), 32'd0);
    tick("to.c17");
    if (TO_EN) begin
      chk("to.c17.state", 32'(st), 32'd0);
      chk("to.c17.err", 32'(err), 32'd1);
      tick("to.blocked");
      chk("to.blocked.state", 32'(st), 32'd0);
      chk("to.blocked.err", 32'(err), 32'd0);
      req = 2'b00;
      tick("to.drop");
      req = 2'b11;
      tick("to.retry");
      chk("to.retry.state", 32'(st), 32'd1);
    end else begin
      ticks(3, "to.off");
      chk("to.off.state", 32'(st), 32'd1);
      chk("to.off.err", 32'(err), 32'd0);
    end
    req = 2'b00;
    tick("to.idle");

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      req      = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3))
                                             : 2'b11;
      quiesced = ($urandom_range(0, 3) != 0);
      xstop    = ($urandom_range(0, 15) == 0);
      lbist    = ($urandom_range(0, 39) == 0);
      gsd      = ($urandom_range(0, 39) == 0);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
